// File: rtl/sm83_sim_bus.sv
// Simulation bus model for the sm83 core: phase timing, mirrored memory, irq scheduler.
// Optional statistics outputs are enabled by defining SIM_BUS_STATS_EN.
module sm83_sim_bus #(
  parameter int CYC_W = 2,
  parameter int ADR_W = 4,
  parameter int IRQ_N = 8,
  parameter int DLY_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  output logic             phi,
  output logic             ncyc,
  input  logic [15:0]      adr,
  input  logic [7:0]       dout,
  input  logic             p_wr,
  output logic [7:0]       din,
  input  logic             dbg_drv,
  input  logic [7:0]       dbg_data,
  input  logic             ld_we,
  input  logic [ADR_W-1:0] ld_adr,
  input  logic [7:0]       ld_data,
  output logic [IRQ_N-1:0] irq,
  input  logic [IRQ_N-1:0] iack,
  input  logic             sch_go,
  input  logic [IRQ_N-1:0] sch_vec,
  input  logic [DLY_W-1:0] sch_dly,
  output logic             sch_busy
`ifdef SIM_BUS_STATS_EN
  ,
  output logic [31:0]      mcyc_cnt,
  output logic [15:0]      wr_cnt,
  output logic [15:0]      last_wr_adr
`endif
);

  localparam int DEPTH = 1 << ADR_W;
  localparam logic [CYC_W-1:0] CYC_NCYC = {1'b1, {(CYC_W-1){1'b0}}};

  typedef enum logic {S_IDLE, S_ARMED} sch_state_e;

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [7:0]       din_q, din_d;
  logic [7:0]       mem_q [DEPTH] = '{default: 8'h00};
  logic [7:0]       mem_d [DEPTH];
  sch_state_e       state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [IRQ_N-1:0] vec_q, vec_d;
  logic [IRQ_N-1:0] irq_q, irq_d;
  logic [IRQ_N-1:0] set_v;
  logic [ADR_W-1:0] cpu_idx;
  logic             cpu_we;
  logic             unused_adr_hi;

  assign cpu_idx       = adr[ADR_W-1:0];
  assign unused_adr_hi = ^adr[15:ADR_W];
  assign phi           = cyc_q[CYC_W-1];
  assign ncyc          = (cyc_q == CYC_NCYC);
  // The ncyc qualifier limits CPU writes to one commit per M-cycle.
  assign cpu_we        = p_wr & ncyc & ~reset;
  assign din           = din_q;
  assign irq           = irq_q;
  assign sch_busy      = (state_q == S_ARMED);

  always_comb begin
    cyc_d = cyc_q + CYC_W'(1);
    din_d = dbg_drv ? dbg_data : mem_q[cpu_idx];
    mem_d = mem_q;
    if (cpu_we) mem_d[cpu_idx] = dout;
    if (ld_we)  mem_d[ld_adr]  = ld_data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    set_v   = '0;
    if (sch_go) begin
      // A new arm (from either state) replaces any count and vector in flight.
      cnt_d = sch_dly;
      vec_d = sch_vec;
      if (sch_dly == '0) begin
        set_v   = sch_vec;
        state_d = S_IDLE;
      end else begin
        state_d = S_ARMED;
      end
    end else if (state_q == S_ARMED && ncyc && cnt_q != '0) begin
      cnt_d = cnt_q - DLY_W'(1);
      if (cnt_q == DLY_W'(1)) begin
        set_v   = vec_q;
        state_d = S_IDLE;
      end
    end
    irq_d = (irq_q & ~iack) | set_v;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q   <= '0;
      din_q   <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      irq_q   <= '0;
    end else begin
      cyc_q   <= cyc_d;
      din_q   <= din_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      irq_q   <= irq_d;
    end
  end

`ifdef SIM_BUS_STATS_EN
  logic [31:0] mcyc_cnt_q, mcyc_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] last_wr_adr_q, last_wr_adr_d;

  always_comb begin
    mcyc_cnt_d    = ncyc ? mcyc_cnt_q + 32'd1 : mcyc_cnt_q;
    wr_cnt_d      = wr_cnt_q;
    last_wr_adr_d = last_wr_adr_q;
    if (cpu_we) begin
      last_wr_adr_d = adr;
      if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcyc_cnt_q    <= '0;
      wr_cnt_q      <= '0;
      last_wr_adr_q <= '0;
    end else begin
      mcyc_cnt_q    <= mcyc_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      last_wr_adr_q <= last_wr_adr_d;
    end
  end

  assign mcyc_cnt    = mcyc_cnt_q;
  assign wr_cnt      = wr_cnt_q;
  assign last_wr_adr = last_wr_adr_q;
`endif

endmodule
